dvp_tx: RTL

Camera-side DVP (OV7670-style) pixel-stream transmitter. It drains 12-bit RGB444 pixels from a FIFO read interface and emits them as an 8-bit parallel byte stream with vsync/href framing: two bytes per pixel, high byte {4'h0,R} first, then {G,B}. This is the byte format and framing the capture path consumes. It serves as a camera emulator for loopback and bring-up, replacing the sensor at the capture input.

---
 rtl/dvp_tx.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/dvp_tx.sv
//------------------------------------------------------------------------------
// dvp_tx : camera-side DVP byte-stream transmitter (camera emulator).
//   Drains 12-bit RGB444 pixels from a FIFO and emits {4'h0,R} then {G,B}
//   with vsync/href framing, two cycles behind the raster counters.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dvp_tx #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BP        = 17,
  parameter int V_FP        = 10
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  output logic        o_rd,
  input  logic [11:0] i_rgb,
  input  logic        i_empty,
  output logic        o_vsync,
  output logic        o_href,
  output logic [7:0]  o_data,
  output logic        o_sof,
  output logic        o_underflow
);

  localparam int H_TOTAL = 2*H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = VSYNC_LINES + V_BP + V_ACTIVE + V_FP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_t;

  state_t        state_q;
  logic [HW-1:0] h_q;
  logic [VW-1:0] v_q;
  logic [HW-1:0] h_d;
  logic [VW-1:0] v_d;

  logic          running;
  logic          h_last;
  logic          frame_end;
  logic          vsync_line;
  logic          active_line;
  logic          byte_slot;
  logic          need_rd;
  logic [11:0]   pix;

  // stage-1 pipeline (counters delayed by one cycle)
  logic          vs1_q;
  logic          hr1_q;
  logic          sof1_q;
  logic          hi1_q;
  logic          rd1_q;
  logic [7:0]    gb_q;

  // Raster decode and next counter values
  always_comb begin
    running     = (state_q != S_IDLE);
    h_last      = (h_q == H_LAST);
    frame_end   = h_last && (v_q == V_LAST);
    vsync_line  = (32'(v_q) < VSYNC_LINES);
    active_line = (32'(v_q) >= VSYNC_LINES + V_BP) &&
                  (32'(v_q) <  VSYNC_LINES + V_BP + V_ACTIVE);
    byte_slot   = active_line && (32'(h_q) < 2*H_ACTIVE);
    need_rd     = running && byte_slot && !h_q[0];
    h_d         = h_last ? '0 : h_q + 1'b1;
    v_d         = v_q;
    if (h_last) begin
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
  end

  // A read is issued only when a pixel is due and the FIFO has one
  assign o_rd = need_rd && !i_empty;
  // Data arrives the cycle after the read; a missed read yields black
  assign pix  = rd1_q ? i_rgb : 12'h000;

  // Run/stop state machine with raster counters; frames are never truncated
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          h_q <= '0;
          v_q <= '0;
          if (i_en) state_q <= S_RUN;
        end
        S_RUN: begin
          h_q <= h_d;
          v_q <= v_d;
          // Dropping enable on the very last cycle already completes the frame
          if (!i_en) state_q <= frame_end ? S_IDLE : S_STOP;
        end
        S_STOP: begin
          h_q <= h_d;
          v_q <= v_d;
          if (frame_end) state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          h_q     <= '0;
          v_q     <= '0;
        end
      endcase
    end
  end

  // Two-stage output pipeline: framing delay, byte serialisation, underflow flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vs1_q       <= 1'b0;
      hr1_q       <= 1'b0;
      sof1_q      <= 1'b0;
      hi1_q       <= 1'b0;
      rd1_q       <= 1'b0;
      gb_q        <= 8'h00;
      o_vsync     <= 1'b0;
      o_href      <= 1'b0;
      o_sof       <= 1'b0;
      o_data      <= 8'h00;
      o_underflow <= 1'b0;
    end else begin
      vs1_q   <= running && vsync_line;
      hr1_q   <= running && byte_slot;
      sof1_q  <= running && (h_q == '0) && (v_q == '0);
      hi1_q   <= !h_q[0];
      rd1_q   <= o_rd;
      o_vsync <= vs1_q;
      o_href  <= hr1_q;
      o_sof   <= sof1_q;
      if (need_rd && i_empty) o_underflow <= 1'b1;
      if (hr1_q && hi1_q) begin
        o_data <= {4'h0, pix[11:8]};
        gb_q   <= pix[7:0];
      end else if (hr1_q) begin
        o_data <= gb_q;
      end else begin
        o_data <= 8'h00;
      end
    end
  end

endmodule

`default_nettype wire
